ahb3lite_irq_capture: RTL and testbench
=======================================

# ahb3lite_irq_capture

AHB3-lite slave that receives up to IRQ_CNT external interrupt lines and collects them into software-visible state. Per-line edge/level mode, pending latch, enable mask. Produces one aggregated interrupt output. Sits on the system AHB bus as the receiving counterpart of the register-driven IRQ generator: captures peripheral IRQs for a host that polls or takes a single interrupt.

## Interface
- IRQ_CNT, 64: number of input lines; multiple of 32, 32..256. NB = IRQ_CNT/32 banks.
- CLK  in  1  system clock; all logic is on the rising edge
- RESET  in  1  asynchronous, active-high reset
- HSEL, HWRITE, HREADY  in  1 each  AHB3-lite slave controls
- HADDR  in  32  byte address; only [11:2] decoded
- HTRANS  in  2; HSIZE, HBURST  in  3; HPROT  in  4  (HBURST, HPROT ignored)
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HRESP  out  1  0=OKAY, 1=ERROR
- HREADYOUT  out  1  slave ready
- IRQ_IN  in  IRQ_CNT  asynchronous interrupt inputs, active-high
- IRQ_OUT  out  1  OR of (pending & enable) over all lines

## Operation
- Register group HADDR[11:10], bank HADDR[9:2] (b < NB):
  - 0 RAW[b]: RO, synchronized input level.
  - 1 MODE[b]: RW, 1=edge, 0=level.
  - 2 ENABLE[b]: RW mask.
  - 3 PENDING[b]: read = edge ? pend_q : RAW; write-1-clears pend_q on edge lines; no effect on level lines.
- Edge detect: rise = sync & ~sync_d. On an edge line, rise sets pend_q. Same-cycle rise and W1C on one bit: set wins.
- Mode change does not alter pend_q. A stale pend_q is hidden while the line is in level mode. It reappears on return to edge mode.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Captured: write flag, group, bank, error flag.
- Error flag is set when:
  - HSIZE != 3'b010, or
  - b >= NB, or
  - the access is a write to RAW.
- Error access: writes have no effect; reads return 0.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
  - DATA: OKAY data phase. HREADYOUT=1. Write commits at end of this cycle using HWDATA. HRDATA is valid this cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1. Then to DATA/ERR1/IDLE depending on the new address phase.
- Accepted OKAY address phase → DATA; accepted error → ERR1. No new address phase is accepted in ERR1 because HREADY is low.
- IRQ_OUT is combinational from pending and ENABLE.

## Timing
- Reset: MODE=0, ENABLE=0, pend_q=0, sync stages=0, sync_d=0, FSM IDLE, HRDATA=0, HRESP=0, HREADYOUT=1, IRQ_OUT=0.
- Because sync_d resets to 0, an input held high across reset release generates one rise.
- Input latency with sync: IRQ_IN high before edge k gives RAW=1 after edge k+1. For an edge line, pend_q=1 and IRQ_OUT=1 (if enabled) after edge k+2.
- Read data reflects register state during the data phase. A read directly after a write to the same register returns the new value.
- Zero wait states for OKAY accesses; back-to-back pipelined transfers are supported.
- W1C takes effect at the end of DATA. IRQ_OUT drops the following cycle unless a same-cycle rise re-set the bit.

## Configuration
- IRQ_CAPTURE_SYNC_EN defined: 2-flop synchronizer on every IRQ_IN bit; latencies as above.
- Not defined: no synchronizer; RAW = IRQ_IN combinationally. A rise sets pend_q at the first edge after it, and level lines propagate to IRQ_OUT combinationally. For synchronous sources only.

## Test plan
- Reset/readback: after RESET, read 0x000/0x400/0x800/0xC00 → all 0, IRQ_OUT=0. Write MODE[0]=0xFFFF0000 → readback 0xFFFF0000.
- Edge capture: MODE[0]=1, ENABLE[0]=1, pulse IRQ_IN[0] for 1 cycle (sync on) → PENDING[0]=1, IRQ_OUT=1 two edges later. Write 0x1 to 0xC00 → PENDING 0, IRQ_OUT 0 next cycle.
- Set vs clear collision: rise on bit 5 in the same cycle as W1C 0x20 → bit 5 remains pending.
- Level mode: MODE=0, ENABLE[1] bit 0=1, hold IRQ_IN[32] high → PENDING[1]=1, W1C ignored; drop input → PENDING 0, IRQ_OUT 0.
- Errors: byte read (HSIZE=0), access to bank NB, write to RAW → each gives a two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1), with no state change.
- Mid-operation reset: assert RESET while pend_q is nonzero and a DATA phase is active → all outputs return to reset values asynchronously, and registers read 0 afterward.

Source files
------------

// File: rtl/ahb3lite_irq_capture.sv
// AHB3-lite slave collecting IRQ_IN lines into RAW/MODE/ENABLE/PENDING banks with one aggregated IRQ_OUT.
// Define IRQ_CAPTURE_SYNC_EN to add a 2-flop synchronizer on every IRQ_IN bit.
module ahb3lite_irq_capture #(
  parameter int unsigned IRQ_CNT = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               HSEL,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [3:0]         HPROT,
  input  logic [31:0]        HWDATA,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic               HREADYOUT,
  input  logic [IRQ_CNT-1:0] IRQ_IN,
  output logic               IRQ_OUT
);
  localparam int unsigned NB = IRQ_CNT / 32;
  localparam logic [7:0] NB_B = 8'(NB);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state;

  logic [IRQ_CNT-1:0] raw, sync_d, mode, enable, pend_q;
  logic [IRQ_CNT-1:0] pend_view, rise, clr, mode_n, en_n;
  logic               a_write;
  logic [1:0]         a_group;
  logic [7:0]         a_bank;
  logic               accept, acc_err;
  logic [31:0]        rd_word;
  logic               unused;

  assign unused = ^{HBURST, HPROT, HADDR[31:12], HADDR[1:0], HTRANS[0]};

`ifdef IRQ_CAPTURE_SYNC_EN
  logic [IRQ_CNT-1:0] sync1, sync2;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IRQ_IN;
      sync2 <= sync1;
    end
  end
  assign raw = sync2;
`else
  assign raw = IRQ_IN;
`endif

  assign rise      = raw & ~sync_d;
  // Level lines expose RAW; edge lines expose the latch, so a stale latch stays hidden in level mode.
  assign pend_view = (mode & pend_q) | (~mode & raw);
  assign IRQ_OUT   = |(pend_view & enable);

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign acc_err = (HSIZE != 3'b010) || (HADDR[9:2] >= NB_B) ||
                   (HWRITE && (HADDR[11:10] == 2'd0));

  always_comb begin
    clr    = '0;
    mode_n = mode;
    en_n   = enable;
    if (state == DATA && a_write) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (a_bank == 8'(b)) begin
          case (a_group)
            2'd1:    mode_n[b*32 +: 32] = HWDATA;
            2'd2:    en_n[b*32 +: 32]   = HWDATA;
            2'd3:    clr[b*32 +: 32]    = HWDATA & mode[b*32 +: 32];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (a_bank == 8'(b)) begin
        case (a_group)
          2'd0:    rd_word = raw[b*32 +: 32];
          2'd1:    rd_word = mode[b*32 +: 32];
          2'd2:    rd_word = enable[b*32 +: 32];
          default: rd_word = pend_view[b*32 +: 32];
        endcase
      end
    end
  end

  assign HRDATA = (state == DATA && !a_write) ? rd_word : '0;

  // A rise in the same cycle as a W1C re-sets the bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_d <= '0;
      mode   <= '0;
      enable <= '0;
      pend_q <= '0;
    end else begin
      sync_d <= raw;
      mode   <= mode_n;
      enable <= en_n;
      pend_q <= (pend_q & ~clr) | (rise & mode);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      a_write   <= 1'b0;
      a_group   <= '0;
      a_bank    <= '0;
    end else if (state == ERR1) begin
      state     <= ERR2;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b1;
    end else if (accept) begin
      a_write   <= HWRITE;
      a_group   <= HADDR[11:10];
      a_bank    <= HADDR[9:2];
      state     <= acc_err ? ERR1 : DATA;
      HREADYOUT <= ~acc_err;
      HRESP     <= acc_err;
    end else begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ahb3lite_irq_capture.sv
// Scoreboard bench for ahb3lite_irq_capture: per-line behavioural model drives expected bus/IRQ responses.
module tb_ahb3lite_irq_capture;
  localparam int unsigned IRQ_CNT = 64;
  localparam int NB = IRQ_CNT / 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               hsel = 1'b0, hwrite = 1'b0;
  logic [31:0]        haddr = '0, hwdata = '0;
  logic [1:0]         htrans = 2'b00;
  logic [2:0]         hsize = 3'b010;
  logic [31:0]        hrdata;
  logic               hresp, hreadyout, irq_out;
  logic [IRQ_CNT-1:0] irq_in = '0;
  logic [IRQ_CNT-1:0] irq_v = '0;

  ahb3lite_irq_capture #(.IRQ_CNT(IRQ_CNT)) dut (
    .CLK(clk), .RESET(rst), .HSEL(hsel), .HWRITE(hwrite), .HREADY(hreadyout),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HWDATA(hwdata), .HRDATA(hrdata), .HRESP(hresp), .HREADYOUT(hreadyout),
    .IRQ_IN(irq_in), .IRQ_OUT(irq_out)
  );

  always #5 clk = ~clk;

  typedef enum {PH_IDLE, PH_DATA, PH_ERR1, PH_ERR2} ph_t;
  typedef struct {
    bit          ready;
    bit          resp;
    bit          irq;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  bit  m_mode[IRQ_CNT], m_en[IRQ_CNT], m_pend[IRQ_CNT];
  bit  m_prev[IRQ_CNT], m_s1[IRQ_CNT], m_s2[IRQ_CNT];
  ph_t m_ph = PH_IDLE;
  bit  m_wr = 1'b0, m_rst = 1'b0;
  int  m_grp = 0, m_bank = 0;
  logic [31:0] wd_next = '0;

  function automatic bit raw_of(input int i);
`ifdef IRQ_CAPTURE_SYNC_EN
    return m_s2[i];
`else
    return irq_in[i];
`endif
  endfunction

  function automatic bit view_of(input int i);
    return m_mode[i] ? m_pend[i] : raw_of(i);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < IRQ_CNT; i++) begin
      m_mode[i] = 0; m_en[i] = 0; m_pend[i] = 0;
      m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end
    m_ph = PH_IDLE; m_wr = 0; m_grp = 0; m_bank = 0;
  endfunction

  // Applies the effect of one rising edge, using the inputs held during the cycle that just ended.
  function automatic void model_edge();
    bit w1c, r, rise, clr, err;
    bit nprev[IRQ_CNT];
    if (m_rst) return;
    w1c = (m_ph == PH_DATA) && m_wr && (m_grp == 3);
    for (int i = 0; i < IRQ_CNT; i++) begin
      r = raw_of(i);
      rise = r && !m_prev[i];
      clr = w1c && (m_bank == i / 32) && hwdata[i % 32] && m_mode[i];
      m_pend[i] = (m_pend[i] && !clr) || (rise && m_mode[i]);
      nprev[i] = r;
    end
    if (m_ph == PH_DATA && m_wr) begin
      for (int j = 0; j < 32; j++) begin
        if (m_grp == 1) m_mode[m_bank * 32 + j] = hwdata[j];
        if (m_grp == 2) m_en[m_bank * 32 + j]   = hwdata[j];
      end
    end
    for (int i = 0; i < IRQ_CNT; i++) begin
      m_prev[i] = nprev[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = irq_in[i];
    end
    if (m_ph == PH_ERR1) m_ph = PH_ERR2;
    else if (hsel && htrans[1]) begin
      m_wr = hwrite; m_grp = int'(haddr[11:10]); m_bank = int'(haddr[9:2]);
      err = (hsize != 3'b010) || (m_bank >= NB) || (hwrite && m_grp == 0);
      m_ph = err ? PH_ERR1 : PH_DATA;
    end else m_ph = PH_IDLE;
  endfunction

  function automatic void push_expect();
    exp_t e;
    int   ln;
    e.ready = (m_ph != PH_ERR1);
    e.resp  = (m_ph == PH_ERR1) || (m_ph == PH_ERR2);
    e.irq   = 0;
    for (int i = 0; i < IRQ_CNT; i++) if (m_en[i] && view_of(i)) e.irq = 1;
    e.chk_rd = !m_wr && (m_ph != PH_IDLE);
    e.rd = '0;
    if (m_ph == PH_DATA && !m_wr) begin
      for (int j = 0; j < 32; j++) begin
        ln = m_bank * 32 + j;
        case (m_grp)
          0:       e.rd[j] = raw_of(ln);
          1:       e.rd[j] = m_mode[ln];
          2:       e.rd[j] = m_en[ln];
          default: e.rd[j] = view_of(ln);
        endcase
      end
    end
    sb.push_back(e);
  endfunction

  task automatic cyc(input bit sel, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [1:0] tr);
    @(posedge clk);
    model_edge();
    #1;
    hsel = sel; hwrite = wr; haddr = a; hsize = sz; htrans = tr;
    hwdata = wd_next; wd_next = wd;
    irq_in = irq_v;
    push_expect();
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 1, a, 3'b010, d, 2'b10);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    cyc(1, 0, a, 3'b010, 32'h0, 2'b10);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 32'h0, 3'b010, 32'h0, 2'b00);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    model_edge();
    #1;
    hsel = 0; hwrite = 0; haddr = '0; htrans = 2'b00;
    hwdata = wd_next; irq_in = irq_v;
    #1;
    rst = 1; m_rst = 1;
    model_reset();
    push_expect();
  endtask

  task automatic hold_reset(input int n);
    idle(n);
    @(posedge clk);
    #1;
    rst = 0; m_rst = 0;
    hsel = 0; htrans = 2'b00;
    push_expect();
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_bit("hreadyout", hreadyout, e.ready);
      check_bit("hresp", hresp, e.resp);
      check_bit("irq_out", irq_out, e.irq);
      if (e.chk_rd) check_word("hrdata", hrdata, e.rd);
    end
  end

  initial begin
    int idx;
    bit sel, wr;
    logic [1:0] grp, tr;
    logic [7:0] bank;
    logic [2:0] sz;

    #2;
    rst = 1; m_rst = 1;
    model_reset();
    hold_reset(3);

    rd_reg(32'h000); rd_reg(32'h400); rd_reg(32'h800); rd_reg(32'hC00); idle(1);
    wr_reg(32'h400, 32'hFFFF_0000); rd_reg(32'h400); idle(1);

    wr_reg(32'h400, 32'h21); wr_reg(32'h800, 32'h21); idle(1);
    irq_v[0] = 1; idle(1); irq_v[0] = 0; idle(3);
    rd_reg(32'hC00); wr_reg(32'hC00, 32'h1); idle(2); rd_reg(32'hC00); idle(1);

    irq_v[5] = 1; idle(1); irq_v[5] = 0; idle(4);
    rd_reg(32'hC00); idle(1);
`ifdef IRQ_CAPTURE_SYNC_EN
    irq_v[5] = 1; idle(1); wr_reg(32'hC00, 32'h20); idle(1);
`else
    wr_reg(32'hC00, 32'h20); irq_v[5] = 1; idle(1);
`endif
    irq_v[5] = 0; idle(3); rd_reg(32'hC00); idle(1);

    wr_reg(32'h804, 32'h1);
    irq_v[32] = 1; idle(3);
    rd_reg(32'hC04); wr_reg(32'hC04, 32'h1); rd_reg(32'hC04);
    irq_v[32] = 0; idle(3); rd_reg(32'hC04); idle(1);

    cyc(1, 0, 32'h000, 3'b000, 32'h0, 2'b10); idle(2);
    rd_reg(32'(NB * 4)); idle(2);
    wr_reg(32'h000, 32'hFFFF_FFFF); idle(2);
    rd_reg(32'h400); rd_reg(32'h800); idle(1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, IRQ_CNT - 1));
        irq_v[idx] = ~irq_v[idx];
      end
      sel  = ($urandom_range(0, 9) < 7);
      tr   = (m_ph == PH_ERR1) ? 2'b00 :
             (($urandom_range(0, 9) < 8) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)));
      bank = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(NB, 255)) : 8'($urandom_range(0, NB - 1));
      sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      wr   = 1'($urandom_range(0, 1));
      grp  = 2'($urandom_range(0, 3));
      cyc(sel, wr, {20'd0, grp, bank, 2'b00}, sz, $urandom, tr);
    end

    irq_v = '0; idle(4);
    wr_reg(32'h400, 32'h1); wr_reg(32'h800, 32'h1); idle(1);
    irq_v[0] = 1; idle(1); irq_v[0] = 0; idle(4);
    rd_reg(32'hC00);
    mid_reset();
    hold_reset(2);
    rd_reg(32'h000); rd_reg(32'h400); rd_reg(32'h800); rd_reg(32'hC00); idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
